// File: rtl/brp_pkg.sv
// Shared types for the direct-mapped branch predictor: 2-bit counter states,
// table entry layout and the tag extraction helper.
package brp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Sized for the smallest table (4 entries), so every ENTRIES choice fits;
    // unused upper tag bits are stored and compared as zero.
    localparam int TAG_W = 28;

    localparam ctr_e CTR_RESET = WNT;
    localparam ctr_e CTR_ALLOC = WT;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        ctr_e             ctr;
    } entry_t;

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
        return TAG_W'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/brp_sat_ctr.sv
// Next-state logic for one 2-bit saturating direction counter.
module brp_sat_ctr
    import brp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // NOTE: default assignment first so no path through the block leaves
    // ctr_next unassigned, which would infer a latch.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Optional build macro BRP_PERF_EN adds saturating branch/mispredict counters.
module branch_predictor
    import brp_pkg::*;
#(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    input  logic [31:0] i_upd_pred_target,
    input  logic        i_clear,
    output logic        o_mispredict
`ifdef BRP_PERF_EN
    ,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
`endif
);

    entry_t           bank [ENTRIES];
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic             lk_hit;
    logic             up_hit;
    logic [1:0]       ctr_next;

    assign lk_idx = i_pc[IDX_W+1:2];
    assign up_idx = i_upd_pc[IDX_W+1:2];

    assign lk_hit = bank[lk_idx].valid && (bank[lk_idx].tag == pc_tag(i_pc, IDX_W));
    assign up_hit = bank[up_idx].valid && (bank[up_idx].tag == pc_tag(i_upd_pc, IDX_W));

    // Lookup reads the registered table only, so an update in flight this
    // cycle is not bypassed to the fetch side.
    assign o_pred_taken  = lk_hit && bank[lk_idx].ctr[1];
    assign o_pred_target = o_pred_taken ? bank[lk_idx].target : i_pc + 32'd4;

    assign o_mispredict = i_upd_valid &&
                          ((i_upd_pred_taken != i_upd_taken) ||
                           (i_upd_taken && (i_upd_pred_target != i_upd_target)));

    brp_sat_ctr u_sat_ctr (
        .ctr      (bank[up_idx].ctr),
        .taken    (i_upd_taken),
        .ctr_next (ctr_next)
    );

    // NOTE: every entry is reset, not just the valid bits, because a reset
    // must wipe learned history completely; state updates use <= so all
    // entries see pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bank[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
        end else if (i_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bank[i].valid <= 1'b0;
            end
        end else if (i_upd_valid) begin
            if (up_hit) begin
                bank[up_idx].ctr <= ctr_e'(ctr_next);
                if (i_upd_taken) bank[up_idx].target <= i_upd_target;
            end else if (i_upd_taken) begin
                // Direct-mapped: a taken miss evicts whatever lives at this index.
                bank[up_idx] <= '{valid:  1'b1,
                                  tag:    pc_tag(i_upd_pc, IDX_W),
                                  target: i_upd_target,
                                  ctr:    CTR_ALLOC};
            end
        end
    end

`ifdef BRP_PERF_EN
    // Counters survive i_clear; only reset zeroes them.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_br_count      <= '0;
            o_mispred_count <= '0;
        end else begin
            if (i_upd_valid && (o_br_count != 32'hFFFF_FFFF)) begin
                o_br_count <= o_br_count + 32'd1;
            end
            if (o_mispredict && (o_mispred_count != 32'hFFFF_FFFF)) begin
                o_mispred_count <= o_mispred_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a small
// address-level reference model of the predictor table.
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic        i_upd_pred_taken;
    logic [31:0] i_upd_pred_target;
    logic        i_clear;
    logic        o_mispredict;
`ifdef BRP_PERF_EN
    logic [31:0] o_br_count;
    logic [31:0] o_mispred_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: per slot, the full PC of the branch that owns it.
    bit          m_valid [ENTRIES];
    logic [31:0] m_pc    [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    longint      m_br_cnt;
    longint      m_mis_cnt;

    logic [31:0] pool [16];

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_pc              (i_pc),
        .o_pred_taken      (o_pred_taken),
        .o_pred_target     (o_pred_target),
        .i_upd_valid       (i_upd_valid),
        .i_upd_pc          (i_upd_pc),
        .i_upd_taken       (i_upd_taken),
        .i_upd_target      (i_upd_target),
        .i_upd_pred_taken  (i_upd_pred_taken),
        .i_upd_pred_target (i_upd_pred_target),
        .i_clear           (i_clear),
        .o_mispredict      (o_mispredict)
`ifdef BRP_PERF_EN
        ,
        .o_br_count        (o_br_count),
        .o_mispred_count   (o_mispred_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int s;
        s = slot(pc);
        return m_valid[s] && ((pc / (4 * ENTRIES)) == (m_pc[s] / (4 * ENTRIES)));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        return i_upd_valid && ((i_upd_pred_taken != i_upd_taken) ||
                               (i_upd_taken && (i_upd_pred_target != i_upd_target)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_pc[i]    = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_br_cnt  = 0;
        m_mis_cnt = 0;
    endtask

    // Applies the effect of the coming clock edge to the model, from the
    // inputs as currently driven.
    task automatic model_edge();
        int s;
        if (i_reset) begin
            model_reset();
        end else begin
            if (i_upd_valid && m_br_cnt < 64'hFFFF_FFFF) m_br_cnt++;
            if (m_mispredict() && m_mis_cnt < 64'hFFFF_FFFF) m_mis_cnt++;
            if (i_clear) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            end else if (i_upd_valid) begin
                s = slot(i_upd_pc);
                if (m_hit(i_upd_pc)) begin
                    if (i_upd_taken) begin
                        m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                        m_tgt[s] = i_upd_target;
                    end else begin
                        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
                    end
                end else if (i_upd_taken) begin
                    m_valid[s] = 1'b1;
                    m_pc[s]    = i_upd_pc;
                    m_tgt[s]   = i_upd_target;
                    m_ctr[s]   = 2;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge i_clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
        i_upd_valid       = v;
        i_upd_pc          = pc;
        i_upd_taken       = taken;
        i_upd_target      = tgt;
        i_upd_pred_taken  = ptaken;
        i_upd_pred_target = ptgt;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken,
                        input logic [31:0] exp_tgt);
        i_pc = pc;
        #1;
        check({tag, "_taken"}, o_pred_taken, exp_taken);
        check({tag, "_target"}, o_pred_target, exp_tgt);
    endtask

    initial begin
        model_reset();
        i_reset = 1'b1;
        i_clear = 1'b0;
        i_pc    = 32'h0000_0100;
        upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        #2;

        // Reset state and an update that arrives during reset
        look("reset_lookup", 32'h0000_0100, 1'b0, 32'h0000_0104);
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        #1;
        check("reset_mispredict", o_mispredict, 1'b1);
        tick();
        tick();
        i_reset = 1'b0;
        upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        look("reset_upd_lost", 32'h100, 1'b0, 32'h104);
        look("wrap_target", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // First taken update allocates; same-cycle lookup sees old contents
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        look("no_bypass", 32'h100, 1'b0, 32'h104);
        check("alloc_mispredict", o_mispredict, 1'b1);
        tick();
        upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        look("after_alloc", 32'h100, 1'b1, 32'h200);

        // Mispredict formula without clocking the update in
        upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        #1;
        check("mis_correct", o_mispredict, 1'b0);
        i_upd_pred_target = 32'h204;
        #1;
        check("mis_bad_target", o_mispredict, 1'b1);
        i_upd_taken = 1'b0;
        #1;
        check("mis_nt_ignores_target", o_mispredict, 1'b1);
        i_upd_pred_taken = 1'b0;
        #1;
        check("mis_nt_correct", o_mispredict, 1'b0);
        i_upd_valid      = 1'b0;
        i_upd_pred_taken = 1'b1;
        #1;
        check("mis_no_valid", o_mispredict, 1'b0);

        // Two not-taken: 10 -> 01 -> 00, then saturate at 00
        upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        tick();
        look("ctr_wnt", 32'h100, 1'b0, 32'h104);
        tick();
        tick();
        tick();
        tick();
        upd(1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h0);
        look("ctr_snt", 32'h100, 1'b0, 32'h104);
        tick();
        look("ctr_sat_low", 32'h100, 1'b0, 32'h104);
        tick();
        upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        look("ctr_relearn", 32'h100, 1'b1, 32'h300);

        // Aliasing branch at the same index evicts the old one
        upd(1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h0);
        tick();
        upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        look("evict_old", 32'h100, 1'b0, 32'h104);
        look("evict_new", 32'h200, 1'b1, 32'h400);

        // Miss with not-taken leaves state untouched
        upd(1'b1, 32'h700, 1'b0, 32'h900, 1'b0, 32'h0);
        tick();
        upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        look("nt_miss_noalloc", 32'h700, 1'b0, 32'h704);

        // Allocation starts weakly taken: one not-taken flips it
        upd(1'b1, 32'h700, 1'b1, 32'h900, 1'b0, 32'h0);
        tick();
        upd(1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 32'h900);
        tick();
        upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        look("alloc_weak", 32'h700, 1'b0, 32'h704);

        // Clear wins over a simultaneous update
        i_clear = 1'b1;
        upd(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
        tick();
        i_clear = 1'b0;
        upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        look("clear_old", 32'h200, 1'b0, 32'h204);
        look("clear_dropped_upd", 32'h500, 1'b0, 32'h504);

        // Randomized traffic over a small aliasing pool of PCs
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (k % 4 == 3) ? ENTRIES - 1 : k % 4;
            pool[k] = (32'(k / 4) << (IDX_W + 2)) | (32'(idx) << 2);
        end
        for (int n = 0; n < 600; n++) begin
            logic [31:0] upc;
            i_pc        = pool[$urandom_range(0, 15)];
            upc         = pool[$urandom_range(0, 15)];
            i_upd_valid = 1'($urandom_range(0, 1));
            i_upd_pc    = upc;
            i_upd_taken = 1'($urandom_range(0, 1));
            i_upd_target = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) begin
                i_upd_pred_taken  = m_taken(upc);
                i_upd_pred_target = m_target(upc);
            end else begin
                i_upd_pred_taken  = 1'($urandom_range(0, 1));
                i_upd_pred_target = $urandom & 32'hFFFF_FFFC;
            end
            i_clear = ($urandom_range(0, 31) == 0);
            #1;
            check("rnd_taken", o_pred_taken, m_taken(i_pc));
            check("rnd_target", o_pred_target, m_target(i_pc));
            check("rnd_mispredict", o_mispredict, m_mispredict());
            tick();
        end
        i_clear = 1'b0;
        upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
`ifdef BRP_PERF_EN
        #1;
        check("rnd_br_count", o_br_count, 32'(m_br_cnt));
        check("rnd_mispred_count", o_mispred_count, 32'(m_mis_cnt));
`endif

        // Make sure the pool has live entries, then reset mid-operation
        for (int k = 0; k < 16; k++) begin
            upd(1'b1, pool[k], 1'b1, 32'h1000 + 32'(k) * 4, 1'b0, 32'h0);
            tick();
        end
        upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        look("pre_reset_live", pool[15], 1'b1, 32'h1000 + 32'd60);
        i_reset = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            look("midop_reset", pool[k], 1'b0, pool[k] + 32'd4);
        end
        tick();
        i_reset = 1'b0;
        tick();
        look("post_reset", pool[3], 1'b0, pool[3] + 32'd4);

`ifdef BRP_PERF_EN
        // Ten updates, three of them mispredicted
        for (int k = 0; k < 10; k++) begin
            upd(1'b1, 32'h800 + 32'(k) * 4, 1'b0, 32'h0, (k < 3), 32'h0);
            tick();
        end
        upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        #1;
        check("perf_br", o_br_count, 32'd10);
        check("perf_mis", o_mispred_count, 32'd3);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("perf_br_clear", o_br_count, 32'd10);
        check("perf_mis_clear", o_mispred_count, 32'd3);
        i_reset = 1'b1;
        #1;
        check("perf_br_reset", o_br_count, 32'd0);
        check("perf_mis_reset", o_mispred_count, 32'd0);
        tick();
        i_reset = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 64, number of predictor entries; power of two, 4..256.
REQ-002 Parameter IDX_W, default $clog2(ENTRIES), index width; derived, not overridden.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_pc  input  32  fetch PC to predict.
REQ-006 o_pred_taken  output  1  prediction for i_pc: 1 = taken.
REQ-007 o_pred_target  output  32  next PC: stored target if predicted taken, else i_pc+4.
REQ-008 i_upd_valid  input  1  branch-resolution update strobe from EX.
REQ-009 i_upd_pc  input  32  PC of the resolved branch.
REQ-010 i_upd_taken  input  1  resolved direction, from the branch compare flags.
REQ-011 i_upd_target  input  32  resolved target address.
REQ-012 i_upd_pred_taken  input  1  prediction made for this branch at fetch.
REQ-013 i_upd_pred_target  input  32  target predicted for this branch at fetch.
REQ-014 i_clear  input  1  synchronous invalidate of all entries.
REQ-015 o_mispredict  output  1  resolved branch disagrees with its prediction.
REQ-016 o_br_count, o_mispred_count  output  32 each  perf counters; present only under BRP_PERF_EN.

Function
REQ-017 Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; each entry holds valid, tag, 32-bit target, 2-bit counter.
REQ-018 Lookup SHALL be combinational: hit = valid & tag match; o_pred_taken = hit & ctr[1]; o_pred_target = o_pred_taken ? target : i_pc+4, modulo 2^32.
REQ-019 Counter SHALL saturate: taken increments toward 2'b11, not-taken decrements toward 2'b00.
REQ-020 Update on i_upd_valid with hit: counter stepped; target overwritten only when i_upd_taken=1.
REQ-021 Update on i_upd_valid with miss and i_upd_taken=1: allocate, valid=1, tag/target written, ctr=2'b10.
REQ-022 Update on i_upd_valid with miss and i_upd_taken=0: no state change.
REQ-023 Update becomes visible to lookup the cycle after the update edge; same-cycle lookup of the same index returns pre-update contents (no bypass).
REQ-024 o_mispredict = i_upd_valid & ((i_upd_pred_taken != i_upd_taken) | (i_upd_taken & i_upd_pred_target != i_upd_target)); combinational.
REQ-025 i_clear SHALL clear every valid bit at the next edge; i_clear has priority over a simultaneous update, which is dropped.
REQ-026 A tag-mismatched allocation SHALL evict the old entry (direct-mapped replacement).

Reset
REQ-027 i_reset asserted SHALL immediately clear all valid bits, set all counters to 2'b01, zero tags and targets, zero perf counters.
REQ-028 During reset o_pred_taken=0, o_pred_target=i_pc+4, o_mispredict as in REQ-024; an update arriving during reset is lost.
REQ-029 Reset asserted mid-operation SHALL discard all learned history with no residual entries.

Configuration
REQ-030 Macro BRP_PERF_EN defined: o_br_count increments per i_upd_valid, o_mispred_count per o_mispredict; both saturate at 32'hFFFF_FFFF and are not cleared by i_clear.
REQ-031 BRP_PERF_EN undefined: perf ports and counters absent; all other behaviour identical.

Structure
REQ-032 Package brp_pkg SHALL hold the counter enum (SNT=00, WNT=01, WT=10, ST=11), the entry struct and the reset-counter constant.
REQ-033 Sub-module brp_sat_ctr SHALL compute the next 2-bit counter value from the current value and the taken bit.

Verification
REQ-034 Reset, i_pc=32'h0000_0100 -> o_pred_taken=0, o_pred_target=32'h0000_0104.
REQ-035 Update pc=32'h100, taken=1, target=32'h200, pred_taken=0 -> o_mispredict=1; next cycle lookup 32'h100 -> taken, target 32'h200.
REQ-036 Same branch not taken twice -> ctr 10->01->00; lookup not taken; three more not-taken updates keep ctr=00.
REQ-037 Allocate pc=32'h100, then taken update pc=32'h200 (same index when ENTRIES=64) -> lookup 32'h100 misses, 32'h200 hits.
REQ-038 i_clear and update asserted in the same cycle -> all lookups miss next cycle; the update is not applied.
REQ-039 BRP_PERF_EN: 10 updates, 3 mispredicted -> o_br_count=10, o_mispred_count=3; i_reset -> both 0.
